// File: rtl/ntt_stream_scoreboard.sv
// ntt_stream_scoreboard: checks a streamed NTT output against a golden memory; define SCB_FIRST_ERR_EN to capture the first mismatch
module ntt_stream_scoreboard #(
  parameter int DATA_W = 23,
  parameter int N = 256,
  parameter int PAT_NUM = 8,
  parameter int TIMEOUT = 100000,
  localparam int AW = $clog2(PAT_NUM*N),
  localparam int PW = $clog2(PAT_NUM)+1,
  localparam int NW = $clog2(N)
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              gold_we,
  input  logic [AW-1:0]     gold_addr,
  input  logic [DATA_W-1:0] gold_wdata,
  input  logic              start,
  input  logic              dut_valid,
  input  logic [DATA_W-1:0] dut_data,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [15:0]       err_cnt,
  output logic [PW-1:0]     out_pat_cnt,
  output logic [NW-1:0]     out_n_cnt,
  output logic [31:0]       cycle_cnt,
  output logic              first_err_valid,
  output logic [AW-1:0]     first_err_idx,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_act
);
  typedef enum logic [1:0] {IDLE, RUN, DONE, TMO} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] pat_q, pat_d;
  logic [NW-1:0] n_q, n_d;
  logic [15:0] err_q, err_d;
  logic [31:0] cyc_q, cyc_d;
  logic busy_q, done_q, pass_q, tmo_q;
  logic [DATA_W-1:0] gold_mem [PAT_NUM*N];
  logic run, acc, last, mis, launch;
  logic [AW-1:0] rd_idx;
  logic [DATA_W-1:0] exp_data;
  assign run = state_q == RUN;
  assign launch = !run && start;
  assign acc = run && dut_valid;
  assign rd_idx = {pat_q[PW-2:0], n_q};
  assign exp_data = gold_mem[rd_idx];
  assign mis = acc && dut_data != exp_data;
  assign last = acc && pat_q == PW'(PAT_NUM-1) && n_q == NW'(N-1);
  always_ff @(posedge clk)
    if (gold_we && !run) gold_mem[gold_addr] <= gold_wdata;
  always_comb begin
    state_d = state_q;
    pat_d = pat_q;
    n_d = n_q;
    err_d = err_q;
    cyc_d = cyc_q;
    if (launch) begin
      state_d = RUN;
      pat_d = '0;
      n_d = '0;
      err_d = '0;
      cyc_d = '0;
    end else if (run) begin
      cyc_d = cyc_q + 32'd1;
      n_d = acc ? n_q + NW'(1) : n_q;
      pat_d = pat_q + PW'(acc && n_q == NW'(N-1));
      err_d = err_q + 16'(mis && err_q != 16'hFFFF);
      // completion outranks timeout when both land on the same cycle
      state_d = last ? DONE : cyc_q == 32'(TIMEOUT-1) ? TMO : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      pat_q <= '0;
      n_q <= '0;
      err_q <= '0;
      cyc_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      n_q <= n_d;
      err_q <= err_d;
      cyc_q <= cyc_d;
      busy_q <= state_d == RUN;
      done_q <= state_d == DONE;
      pass_q <= state_d == DONE && err_d == 16'd0;
      tmo_q <= state_d == TMO;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign pass = pass_q;
  assign timeout = tmo_q;
  assign err_cnt = err_q;
  assign out_pat_cnt = pat_q;
  assign out_n_cnt = n_q;
  assign cycle_cnt = cyc_q;
`ifdef SCB_FIRST_ERR_EN
  logic fv_q, fv_d;
  logic [AW-1:0] fi_q, fi_d;
  logic [DATA_W-1:0] fe_q, fe_d, fa_q, fa_d;
  always_comb begin
    fv_d = fv_q;
    fi_d = fi_q;
    fe_d = fe_q;
    fa_d = fa_q;
    if (launch) begin
      fv_d = 1'b0;
      fi_d = '0;
      fe_d = '0;
      fa_d = '0;
    end else if (mis && !fv_q) begin
      fv_d = 1'b1;
      fi_d = rd_idx;
      fe_d = exp_data;
      fa_d = dut_data;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      fv_q <= 1'b0;
      fi_q <= '0;
      fe_q <= '0;
      fa_q <= '0;
    end else begin
      fv_q <= fv_d;
      fi_q <= fi_d;
      fe_q <= fe_d;
      fa_q <= fa_d;
    end
  end
  assign first_err_valid = fv_q;
  assign first_err_idx = fi_q;
  assign first_err_exp = fe_q;
  assign first_err_act = fa_q;
`else
  assign first_err_valid = 1'b0;
  assign first_err_idx = '0;
  assign first_err_exp = '0;
  assign first_err_act = '0;
`endif
endmodule

// File: doc/ntt_stream_scoreboard.md
NTT_STREAM_SCOREBOARD -- requirements
Module: ntt_stream_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_W, default 23, meaning the coefficient width in bits.
REQ-002 The block SHALL have parameter N, default 256, meaning coefficients per pattern (power of two).
REQ-003 The block SHALL have parameter PAT_NUM, default 8, meaning patterns per run (power of two).
REQ-004 The block SHALL have parameter TIMEOUT, default 100000, meaning maximum RUN cycles before abort.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is clocked on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, a synchronous, active-low reset.
REQ-007 The block SHALL have port gold_we, input, 1 bit, the golden-memory write strobe.
REQ-008 The block SHALL have port gold_addr, input, clog2(PAT_NUM*N) bits, the golden write index (pat*N+n).
REQ-009 The block SHALL have port gold_wdata, input, DATA_W bits, the golden write data.
REQ-010 The block SHALL have port start, input, 1 bit, a request to begin a checking run.
REQ-011 The block SHALL have ports dut_valid (input, 1 bit) and dut_data (input, DATA_W bits), the observed output stream; no back-pressure.
REQ-012 The block SHALL have port busy, output, 1 bit, high in RUN.
REQ-013 The block SHALL have ports done, pass and timeout, outputs, 1 bit each, giving run status.
REQ-014 The block SHALL have port err_cnt, output, 16 bits, the mismatch count.
REQ-015 The block SHALL have ports out_pat_cnt (clog2(PAT_NUM)+1 bits) and out_n_cnt (clog2(N) bits), outputs, the position of the next expected sample.
REQ-016 The block SHALL have port cycle_cnt, output, 32 bits, the RUN cycle count.
REQ-017 The block SHALL have ports first_err_valid (1 bit), first_err_idx (clog2(PAT_NUM*N) bits), first_err_exp and first_err_act (DATA_W bits each), outputs.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DONE and TMO.
REQ-019 In any state except RUN, gold_we=1 SHALL write gold_wdata to golden[gold_addr] at the clock edge; writes in RUN SHALL be ignored.
REQ-020 start=1 in IDLE, DONE or TMO SHALL enter RUN at the next edge and clear err_cnt, the position counters, cycle_cnt and the first-error fields; start in RUN SHALL be ignored.
REQ-021 In RUN, each cycle with dut_valid=1 SHALL compare dut_data against golden[out_pat_cnt*N+out_n_cnt] using a combinational read, and SHALL then advance out_n_cnt, wrapping N-1 to 0 with out_pat_cnt incremented on the wrap.
REQ-022 A mismatch SHALL increment err_cnt at the same edge, saturating at 16'hFFFF.
REQ-023 cycle_cnt SHALL increment on every RUN cycle.
REQ-024 Acceptance of sample (PAT_NUM-1, N-1) SHALL enter DONE at that edge, so that done=1 on the following cycle.
REQ-025 A RUN cycle with cycle_cnt==TIMEOUT-1 and no final sample SHALL enter TMO.
REQ-026 When the final sample and the timeout condition occur in the same cycle, completion SHALL win and the FSM SHALL enter DONE.
REQ-027 dut_valid outside RUN SHALL be ignored, with no counter change.
REQ-028 done SHALL be high only in DONE, timeout only in TMO, and pass = done AND (err_cnt==0); all results SHALL hold until the next start.

Reset
REQ-029 While rst=0 at a clock edge, the FSM SHALL enter IDLE and busy, done, pass, timeout, err_cnt, out_pat_cnt, out_n_cnt, cycle_cnt and all first_err_* outputs SHALL become 0.
REQ-030 Reset asserted mid-RUN SHALL abort the run with no done or timeout pulse.
REQ-031 Golden memory contents SHALL NOT be reset.

Configuration
REQ-032 With macro SCB_FIRST_ERR_EN defined, the first mismatch of a run SHALL latch first_err_valid=1 together with its index, expected value and actual value, and later mismatches SHALL NOT overwrite them.
REQ-033 Without SCB_FIRST_ERR_EN, all first_err_* ports SHALL remain present and SHALL be tied to 0, with no capture logic.

Verification (N=4, PAT_NUM=2, TIMEOUT=20)
REQ-034 Scenario: golden=0..7, start, stream 0..7 on consecutive cycles -> done=1 one cycle after the last sample, pass=1, err_cnt=0, cycle_cnt=8.
REQ-035 Scenario: same stream with sample 5 = 23'h7FFFFF -> err_cnt=1, pass=0, first_err_idx=5, first_err_exp=5, first_err_act=7FFFFF (macro defined; all 0 without it).
REQ-036 Scenario: start, then 3 samples only -> timeout=1 after 20 RUN cycles, done=0, out_pat_cnt=0, out_n_cnt=3.
REQ-037 Scenario: final sample arrives on RUN cycle 20 -> DONE, timeout=0.
REQ-038 Scenario: rst=0 after 4 samples, then restart with a full stream -> outputs 0 during reset, golden retained, then pass=1.
REQ-039 Scenario: gold_we during RUN and dut_valid in IDLE -> golden unchanged, counters unchanged.
